// File: rtl/viterbi_pkg.sv
// Shared types and code definition for the K=3, rate-1/2 (7,5) link.
// Used by conv_encoder (tx) and viterbi_decoder (rx).
package viterbi_pkg;

    localparam int         K       = 3;
    localparam int         NSTATES = 4;
    localparam logic [2:0] G0      = 3'b111;
    localparam logic [2:0] G1      = 3'b101;

    // {previous bit, bit before that}
    typedef logic [1:0] state_t;

    // Channel symbol {g0, g1} emitted when bit b leaves state s.
    function automatic logic [1:0] exp_sym(state_t s, logic b);
        logic [2:0] w_reg;
        w_reg = {b, s};
        return {^(w_reg & G0), ^(w_reg & G1)};
    endfunction

    // Hamming distance between two symbols (0..2).
    function automatic logic [1:0] sym_dist(logic [1:0] a, logic [1:0] b);
        logic [1:0] w_x;
        w_x = a ^ b;
        return {1'b0, w_x[1]} + {1'b0, w_x[0]};
    endfunction

endpackage

// File: rtl/acs_unit.sv
// Compare-select for one trellis state.
// Ports: i_cand0/i_cand1 candidate metrics, o_pm winner, o_sel 1 = cand1 won.
module acs_unit #(
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0] i_cand0,
    input  logic [PM_W-1:0] i_cand1,
    output logic [PM_W-1:0] o_pm,
    output logic            o_sel
);

    // Strict compare: a tie keeps candidate 0.
    assign o_sel = (i_cand1 < i_cand0);
    assign o_pm  = o_sel ? i_cand1 : i_cand0;

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 (7,5) convolutional encoder, registered output.
// Ports: clk, rst (async low), enable_i, d_in bit -> valid_o, d_out symbol.
module conv_encoder
    import viterbi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       d_in,
    output logic       valid_o,
    output logic [1:0] d_out
);

    state_t r_sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr    <= '0;
            valid_o <= 1'b0;
            d_out   <= '0;
        end else begin
            valid_o <= enable_i;
            if (enable_i) begin
                d_out <= exp_sym(r_sr, d_in);
                r_sr  <= {d_in, r_sr[1]};
            end
        end
    end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder for the (7,5) K=3 code.
// Ports: clk, rst (async low), enable, d_in symbol -> d_out decoded bit.
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] d_in,
    output logic       d_out
);

    localparam logic [PM_W-1:0] PM_INIT = PM_W'(16);

    logic [NSTATES-1:0][PM_W-1:0]     r_pm;
    logic [NSTATES-1:0][TB_DEPTH-1:0] r_surv;
    logic                             r_dout;

    logic [NSTATES-1:0][PM_W-1:0]     w_pm_new;
    logic [NSTATES-1:0]               w_sel;
    logic [NSTATES-1:0][TB_DEPTH-1:0] w_surv_new;
    logic [PM_W-1:0]                  w_min;
    state_t                           w_min_idx;

    // Next state n = {b, p} is reached from {p,0} or {p,1} on input b.
    for (genvar n = 0; n < NSTATES; n++) begin : g_acs
        localparam logic [1:0] NS = 2'(n);
        localparam state_t     PA = {NS[0], 1'b0};
        localparam state_t     PB = {NS[0], 1'b1};
        localparam logic       B  = NS[1];

        logic [PM_W-1:0] w_c0;
        logic [PM_W-1:0] w_c1;

        assign w_c0 = r_pm[PA] + PM_W'(sym_dist(d_in, exp_sym(PA, B)));
        assign w_c1 = r_pm[PB] + PM_W'(sym_dist(d_in, exp_sym(PB, B)));

        acs_unit #(
            .PM_W (PM_W)
        ) u_acs (
            .i_cand0 (w_c0),
            .i_cand1 (w_c1),
            .o_pm    (w_pm_new[n]),
            .o_sel   (w_sel[n])
        );

        assign w_surv_new[n] = w_sel[n]
            ? {r_surv[PB][TB_DEPTH-2:0], B}
            : {r_surv[PA][TB_DEPTH-2:0], B};
    end

    // Lowest index wins a tie because the compare is strict.
    always_comb begin
        w_min     = w_pm_new[0];
        w_min_idx = '0;
        for (int i = 1; i < NSTATES; i++) begin
            if (w_pm_new[i] < w_min) begin
                w_min     = w_pm_new[i];
                w_min_idx = state_t'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pm   <= {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
            r_surv <= '0;
            r_dout <= 1'b0;
        end else if (enable) begin
            for (int i = 0; i < NSTATES; i++) begin
                r_pm[i] <= w_pm_new[i] - w_min;
            end
            r_surv <= w_surv_new;
            r_dout <= w_surv_new[w_min_idx][TB_DEPTH-1];
        end
    end

    assign d_out = r_dout;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Randomised self-checking bench for viterbi_decoder and conv_encoder.
// Reference: info-bit history queue, generator-polynomial symbols.
module tb_viterbi_decoder;

    import viterbi_pkg::*;

    localparam int TBD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] d_in;
    logic       d_out;
    logic       enc_en;
    logic       enc_din;
    logic       enc_valid;
    logic [1:0] enc_dout;

    int checks   = 0;
    int failures = 0;

    bit         bits[$];
    logic [1:0] last_sym;

    always #5 clk = ~clk;

    viterbi_decoder #(
        .TB_DEPTH (TBD),
        .PM_W     (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .d_in   (d_in),
        .d_out  (d_out)
    );

    conv_encoder u_enc (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enc_en),
        .d_in     (enc_din),
        .valid_o  (enc_valid),
        .d_out    (enc_dout)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Symbol for info bit idx: g0 = b^b-1^b-2, g1 = b^b-2.
    function automatic logic [1:0] model_sym(int idx);
        bit b0, b1, b2;
        b0 = bits[idx];
        b1 = (idx >= 1) ? bits[idx-1] : 1'b0;
        b2 = (idx >= 2) ? bits[idx-2] : 1'b0;
        return {b0 ^ b1 ^ b2, b0 ^ b2};
    endfunction

    // After n symbols the output is bit n-TBD+1 (1-based), else 0.
    function automatic logic exp_dec();
        int n;
        n = bits.size();
        return (n >= TBD) ? bits[n-TBD] : 1'b0;
    endfunction

    task automatic sym_step(input bit b, input logic [1:0] flip);
        logic [1:0] s;
        @(negedge clk);
        bits.push_back(b);
        s        = model_sym(bits.size() - 1);
        last_sym = s;
        enable   = 1'b1;
        enc_en   = 1'b1;
        enc_din  = b;
        d_in     = s ^ flip;
        @(posedge clk);
        #1;
        check("dec_out", d_out, exp_dec());
        check("enc_sym", enc_dout, s);
        check("enc_valid", enc_valid, 1);
    endtask

    task automatic idle_step();
        @(negedge clk);
        enable  = 1'b0;
        enc_en  = 1'b0;
        enc_din = 1'($urandom);
        d_in    = 2'($urandom);
        @(posedge clk);
        #1;
        check("gap_dec", d_out, exp_dec());
        check("gap_enc", enc_dout, last_sym);
        check("gap_valid", enc_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b0;
        enc_en = 1'b0;
        #1;
        check("rst_dec", d_out, 0);
        check("rst_enc", enc_dout, 0);
        check("rst_valid", enc_valid, 0);
        bits.delete();
        last_sym = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pm0", dut.r_pm[0], 0);
        check("rst_pm1", dut.r_pm[1], 16);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Flip d_in[0] on symbols 14 and 15 of every 16 (1-based).
    function automatic logic [1:0] err_flip();
        int k;
        k = (bits.size() + 1) % 16;
        return (k == 14 || k == 15) ? 2'b01 : 2'b00;
    endfunction

    task automatic run_stream(input int len, input bit errs);
        for (int i = 0; i < len; i++) begin
            logic [1:0] f;
            f = errs ? err_flip() : 2'b00;
            sym_step(1'($urandom), f);
        end
    endtask

    initial begin
        logic [1:0] vec_sym [6];
        bit         vec_bit [6];
        vec_bit = '{1, 0, 1, 1, 0, 0};
        vec_sym = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

        rst      = 1'b0;
        enable   = 1'b0;
        enc_en   = 1'b0;
        enc_din  = 1'b0;
        d_in     = 2'b00;
        last_sym = '0;

        do_reset();

        for (int i = 0; i < 6; i++) begin
            sym_step(vec_bit[i], 2'b00);
            check("enc_vec", enc_dout, vec_sym[i]);
        end
        idle_step();

        do_reset();
        run_stream(256, 1'b0);

        do_reset();
        run_stream(256, 1'b1);

        do_reset();
        run_stream(40, 1'b1);
        repeat (5) idle_step();
        run_stream(40, 1'b1);

        run_stream(30, 1'b0);
        do_reset();
        run_stream(100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
